// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer for the MIPS core.
//   Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns the architectural HI/LO pair,
//   drives an external pipelined multiplier (fixed latency MUL_LATENCY) and
//   runs an internal 32-step restoring divider.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   op_valid, op        request strobe and 3-bit op code (110/111 reserved)
//   op_a, op_b          rs / rt operands
//   busy, done          op in flight / one-cycle completion pulse
//   hi, lo              architectural HI / LO
//   mul_a, mul_b        latched multiplier operands
//   mul_signed          1 = signed multiply
//   mul_hi, mul_lo      product returned by the external multiplier
module muldiv_ctrl #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_ITER = 2'd2,
    S_DIV_FIX  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        mul_signed_q, mul_signed_d;
  logic        busy_q, busy_d, done_q, done_d;
  // quo_q starts as the dividend magnitude and fills with quotient bits
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic        div_signed_s;
  logic [32:0] rem_sh_s, diff_s;

  assign div_signed_s = ~op[0];
  // One restoring step: shift next dividend bit into the partial remainder,
  // then trial-subtract; bit 32 of the difference is the borrow.
  assign rem_sh_s = {rem_q, quo_q[31]};
  assign diff_s   = rem_sh_s - {1'b0, dvs_q};

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_signed_d = mul_signed_q;
    done_d       = 1'b0;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvs_d        = dvs_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            3'b000, 3'b001: begin
              mul_a_d      = op_a;
              mul_b_d      = op_b;
              mul_signed_d = ~op[0];
              cnt_d        = 6'd0;
              state_d      = S_MUL_WAIT;
            end
            3'b010, 3'b011: begin
              if (op_b == 32'd0) begin
                // Divide by zero: skip iterations, fixed result, no sign fixup
                quo_d   = 32'hFFFF_FFFF;
                rem_d   = op_a;
                q_neg_d = 1'b0;
                r_neg_d = 1'b0;
                state_d = S_DIV_FIX;
              end else begin
                dvs_d   = (div_signed_s && op_b[31]) ? (32'd0 - op_b) : op_b;
                quo_d   = (div_signed_s && op_a[31]) ? (32'd0 - op_a) : op_a;
                q_neg_d = div_signed_s & (op_a[31] ^ op_b[31]);
                r_neg_d = div_signed_s & op_a[31];
                rem_d   = 32'd0;
                cnt_d   = 6'd0;
                state_d = S_DIV_ITER;
              end
            end
            3'b100: begin
              hi_d   = op_a;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = op_a;
              done_d = 1'b1;
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_WAIT: begin
        if (cnt_q == MUL_LAST) begin
          hi_d    = mul_hi;
          lo_d    = mul_lo;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DIV_ITER: begin
        if (!diff_s[32]) begin
          rem_d = diff_s[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh_s[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == DIV_LAST) begin
          state_d = S_DIV_FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DIV_FIX: begin
        lo_d    = q_neg_q ? (32'd0 - quo_q) : quo_q;
        hi_d    = r_neg_q ? (32'd0 - rem_q) : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 6'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      mul_a_q      <= 32'd0;
      mul_b_q      <= 32'd0;
      mul_signed_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rem_q        <= 32'd0;
      quo_q        <= 32'd0;
      dvs_q        <= 32'd0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_signed_q <= mul_signed_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvs_q        <= dvs_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_signed = mul_signed_q;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

- Sequencing controller for the HI/LO multiply/divide path of the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the decode/execute stage and owns the architectural HI and LO registers.
- Drives the external pipelined multiplier and counts its latency.
- Contains its own 32-iteration restoring divider. Raises `busy` so the pipeline stalls MFHI/MFLO and further HI/LO ops until results land.

## Interface
Parameters:
- MUL_LATENCY, 2, cycles from operands on `mul_a`/`mul_b` to valid `mul_hi`/`mul_lo`; legal range 1..8.

Ports:
- clk  in  1  single clock; everything is rising-edge triggered.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  request present this cycle.
- op  in  3  op code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are reserved.
- op_a  in  32  rs operand (dividend / MTHI/MTLO source).
- op_b  in  32  rt operand (divisor).
- busy  out  1  op in flight; new requests are not accepted.
- done  out  1  one-cycle pulse in the cycle after HI/LO is written.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- mul_a  out  32  multiplier operand A (latched).
- mul_b  out  32  multiplier operand B (latched).
- mul_signed  out  1  1 = signed multiply.
- mul_hi  in  32  multiplier product upper word.
- mul_lo  in  32  multiplier product lower word.

## Operation
- Accept rule: a request is accepted at a rising edge where `op_valid && !busy`. Requests with `busy=1` are ignored; the requester holds them.
- States: IDLE, MUL_WAIT, DIV_ITER, DIV_FIX.
- IDLE, MTHI/MTLO: the write of `op_a` happens at the accept edge. No busy. State stays IDLE.
- IDLE, reserved op: accepted. No HI/LO change. `done` pulses.
- IDLE, MULT/MULTU:
  - Latch `op_a`/`op_b` into `mul_a`/`mul_b`; set `mul_signed = ~op[0]`; `cnt=0`; go to MUL_WAIT.
  - MUL_WAIT increments `cnt` each edge.
  - At the edge where `cnt == MUL_LATENCY-1`, capture `hi=mul_hi` and `lo=mul_lo`, then go to IDLE.
- IDLE, DIV/DIVU, `op_b != 0`:
  - Latch divisor magnitude and dividend magnitude (absolute values if signed, raw if unsigned); record the quotient sign and remainder sign.
  - Set `rem=0`, `cnt=0`; go to DIV_ITER.
- DIV_ITER performs one restoring step per edge:
  - shift {rem, dividend} left 1;
  - if rem ≥ divisor, subtract it and set the quotient bit.
  - After the 32nd step, go to DIV_FIX.
- DIV_FIX: negate the quotient if `a[31]^b[31]` (signed only). Negate the remainder if `a[31]` (signed only). Write `lo=quotient`, `hi=remainder`. Go to IDLE.
- Divide by zero (either signedness): go directly to DIV_FIX with quotient = 0xFFFFFFFF, remainder = `op_a`, and no sign fixup.
- Overflow 0x80000000 / 0xFFFFFFFF (signed) yields lo=0x80000000, hi=0 via the magnitude path. No special case.
- `mul_a`, `mul_b` and `mul_signed` hold their last latched values while IDLE.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, mul_a=0, mul_b=0, mul_signed=0, state IDLE, cnt=0.
- Reset asserted mid-operation aborts it. HI/LO go to 0 and no `done` is produced.
- Edge numbering: accept edge = E0.
- MULT/MULTU:
  - HI/LO written at E(MUL_LATENCY).
  - `busy` high for MUL_LATENCY cycles (after E0 until E(MUL_LATENCY)).
  - `done` high for the cycle after E(MUL_LATENCY).
- DIV/DIVU, nonzero divisor:
  - Iterations at E1..E32; HI/LO written at E33.
  - `busy` high for 33 cycles; `done` in the cycle after E33.
- Divide by zero: HI/LO written at E1; `busy` for 1 cycle.
- MTHI/MTLO/reserved: the write happens at E0, `busy` stays 0, and `done` is high in the cycle after E0.
- Back-to-back issue:
  - A new op may be accepted on the same edge that `busy` falls, i.e. the first edge with `busy=0` sampled, which is the cycle `done` is high.
  - The HI/LO values visible that cycle are the completed result.
- `hi`/`lo` change only at write edges. They are stable and readable (MFHI/MFLO) whenever `busy=0`.

## Test plan
- Reset, then MULT 0xFFFFFFFF × 0x00000002 with MUL_LATENCY=2 and a model multiplier:
  - hi=0xFFFFFFFF, lo=0xFFFFFFFE at E2;
  - busy high exactly 2 cycles; done one cycle.
- MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF at E33, busy 33 cycles.
- DIVU 100 / 7 → lo=0x0000000E, hi=0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=0x00000005 at E1.
- MTHI 0x12345678 issued while a DIVU is busy → ignored.
  - Re-issued when `done` is high → hi=0x12345678 at that edge; busy stays 0.
- Reset asserted at E10 of a DIV → hi=lo=0, busy=0, no done.
  - A following MTLO 0xA5A5A5A5 writes normally.
